// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing, colour-bar table and counter-width helper
package vga_pkg;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP = 33;
    // {r,g,b} on/off per bar; index 0 is the leftmost (white) bar
    localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
    function automatic int cnt_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis counter with active/sync decode and wrap strobe
module vga_axis_counter import vga_pkg::*; #(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP = DEF_H_FP,
    parameter int SYNC = DEF_H_SYNC,
    parameter int BP = DEF_H_BP,
    localparam int TOT = ACTIVE + FP + SYNC + BP,
    localparam int W = cnt_w(TOT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0] cnt_x;
    // one spare bit so bounds equal to 2**W still compare correctly
    assign cnt_x = {1'b0, cnt_q};
    assign wrap = inc && cnt_x == (W+1)'(TOT - 1);
    assign cnt_d = wrap ? '0 : cnt_q + W'(inc);
    assign active = cnt_x < (W+1)'(ACTIVE);
    assign sync = cnt_x >= (W+1)'(ACTIVE + FP) && cnt_x < (W+1)'(ACTIVE + FP + SYNC);
    assign cnt = cnt_q;
    always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/DE/pixel timing with frame-aligned 2x pixel doubling.
// Define VGA_PATTERN_EN to add pat_sel and the built-in test patterns.
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP = DEF_V_BP,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int COLOR_W = 4,
    localparam int XW = cnt_w(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int YW = cnt_w(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [3*COLOR_W-1:0] pix_in,
`ifdef VGA_PATTERN_EN
    input  logic [1:0]           pat_sel,
`endif
    output logic [XW-1:0]        x,
    output logic [YW-1:0]        y,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 hs,
    output logic                 vs,
    output logic                 de,
    output logic                 frame_start,
    output logic [7:0]           frame_cnt
);
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic h_act, h_sync, h_wrap, v_act, v_sync, v_wrap;
    logic sof_q, mode_q, de_q, hs_q, vs_q, fs_q;
    logic [7:0] fcnt_q;
    logic [3*COLOR_W-1:0] src, rgb_q;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
        .clk(clk), .rst(rst), .inc(1'b1), .cnt(h_cnt), .active(h_act), .sync(h_sync), .wrap(h_wrap));
    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
        .clk(clk), .rst(rst), .inc(h_wrap), .cnt(v_cnt), .active(v_act), .sync(v_sync), .wrap(v_wrap));

    assign x = mode_q ? h_cnt >> 1 : h_cnt;
    assign y = mode_q ? v_cnt >> 1 : v_cnt;

`ifdef VGA_PATTERN_EN
    logic [31:0] xe, ye;
    logic [2:0] bar;
    logic [COLOR_W-1:0] grey;
    assign xe = 32'(x);
    assign ye = 32'(y);
    assign bar = BAR_RGB[3'(xe / 32'(H_ACTIVE / 8))];
    assign grey = xe[COLOR_W+5:6];
    assign src = pat_sel == 2'd1 ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}}
               : pat_sel == 2'd2 ? {(3*COLOR_W){xe[4] ^ ye[4]}}
               : pat_sel == 2'd3 ? {3{grey}} : pix_in;
`else
    assign src = pix_in;
`endif

    // sof_q marks the cycle with both counters at 0; reset leaves them there too
    always_ff @(posedge clk) begin
        if (!rst) begin
            sof_q <= 1'b1;
            mode_q <= 1'b0;
            de_q <= 1'b0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            fs_q <= 1'b0;
            fcnt_q <= 8'd0;
            rgb_q <= '0;
        end else begin
            sof_q <= v_wrap;
            mode_q <= sof_q ? mode : mode_q;
            de_q <= h_act && v_act;
            hs_q <= h_sync ? HS_POL : ~HS_POL;
            vs_q <= v_sync ? VS_POL : ~VS_POL;
            fs_q <= sof_q;
            fcnt_q <= fcnt_q + 8'(sof_q);
            rgb_q <= h_act && v_act ? src : '0;
        end
    end

    assign {r, g, b} = rgb_q;
    assign de = de_q;
    assign hs = hs_q;
    assign vs = vs_q;
    assign frame_start = fs_q;
    assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default 640x480 instance and a small
// 80x22-total instance that keeps whole-frame scenarios short.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic rst_a = 1'b0, rst_b = 1'b0, mode_a = 1'b0, mode_b = 1'b0;
    logic [11:0] pix = 12'hFFF;

    logic [9:0] x_a, y_a;
    logic [3:0] r_a, g_a, b_a;
    logic hs_a, vs_a, de_a, fs_a;
    logic [7:0] fc_a;

    logic [6:0] x_b;
    logic [4:0] y_b;
    logic [3:0] r_b, g_b, b_b;
    logic hs_b, vs_b, de_b, fs_b;
    logic [7:0] fc_b;

`ifdef VGA_PATTERN_EN
    logic [1:0] pat_a = 2'd0;
    logic [1:0] pat_b = 2'd0;
`endif

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .mode(mode_a), .pix_in(pix),
`ifdef VGA_PATTERN_EN
        .pat_sel(pat_a),
`endif
        .x(x_a), .y(y_a), .r(r_a), .g(g_a), .b(b_a), .hs(hs_a), .vs(vs_a), .de(de_a),
        .frame_start(fs_a), .frame_cnt(fc_a));

    vga_timing_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                     .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_b (
        .clk(clk), .rst(rst_b), .mode(mode_b), .pix_in(pix),
`ifdef VGA_PATTERN_EN
        .pat_sel(pat_b),
`endif
        .x(x_b), .y(y_b), .r(r_b), .g(g_b), .b(b_b), .hs(hs_b), .vs(vs_b), .de(de_b),
        .frame_start(fs_b), .frame_cnt(fc_b));

    task automatic reset_b();
        rst_b = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({x_a, y_a} !== 20'd0) begin errors++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x_a, y_a); end
        checks++; if ({hs_a, vs_a, de_a, fs_a} !== 4'b1100) begin errors++; $display("FAIL reset_ctrl: got hs/vs/de/fs=%b expected 1100", {hs_a, vs_a, de_a, fs_a}); end
        checks++; if ({r_a, g_a, b_a} !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h expected 000", {r_a, g_a, b_a}); end
        checks++; if (fc_a !== 8'd0) begin errors++; $display("FAIL reset_fcnt: got %0d expected 0", fc_a); end
    endtask

    task automatic test_line_timing();
        int f1, f2, len, de_n;
        logic p;
        f1 = 0; f2 = 0; len = 0; de_n = 0; p = 1'b1;
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 1; k <= 1500; k++) begin
            @(posedge clk); #1;
            if (p && !hs_a) begin
                if (f1 == 0) f1 = k;
                else if (f2 == 0) f2 = k;
            end
            if (!p && hs_a && len == 0) len = k - f1;
            if (k <= 800 && de_a) de_n++;
            p = hs_a;
        end
        checks++; if (f1 !== 657) begin errors++; $display("FAIL hs_first_low: got cycle %0d expected 657", f1); end
        checks++; if (len !== 96) begin errors++; $display("FAIL hs_width: got %0d expected 96", len); end
        checks++; if (f2 - f1 !== 800) begin errors++; $display("FAIL hs_period: got %0d expected 800", f2 - f1); end
        checks++; if (de_n !== 640) begin errors++; $display("FAIL line_de: got %0d expected 640", de_n); end
    endtask

`ifdef VGA_PATTERN_EN
    task automatic test_pattern();
        pat_a = 2'd1;
        rst_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 1; k <= 601; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin checks++; if ({r_a, g_a, b_a} !== 12'hFFF) begin errors++; $display("FAIL bar_x0: got %h expected FFF", {r_a, g_a, b_a}); end end
            if (k == 81) begin checks++; if ({r_a, g_a, b_a} !== 12'hFF0) begin errors++; $display("FAIL bar_x80: got %h expected FF0", {r_a, g_a, b_a}); end end
            if (k == 241) begin checks++; if ({r_a, g_a, b_a} !== 12'h0F0) begin errors++; $display("FAIL bar_x240: got %h expected 0F0", {r_a, g_a, b_a}); end end
            if (k == 601) begin checks++; if ({r_a, g_a, b_a} !== 12'h000) begin errors++; $display("FAIL bar_x600: got %h expected 000", {r_a, g_a, b_a}); end end
        end
        pat_a = 2'd0;
    endtask
`endif

    task automatic test_frame();
        int p[3];
        int n, fc1, fc3, vf, vr;
        logic pv;
        p = '{0, 0, 0}; n = 0; fc1 = -1; fc3 = -1; vf = 0; vr = 0; pv = 1'b1;
        mode_b = 1'b0;
        reset_b();
        for (int k = 1; k <= 5270; k++) begin
            @(posedge clk); #1;
            if (fs_b) begin
                if (n < 3) p[n] = k;
                if (n == 0) fc1 = int'(fc_b);
                if (n == 2) fc3 = int'(fc_b);
                n++;
            end
            if (pv && !vs_b && vf == 0) vf = k;
            if (!pv && vs_b && vr == 0) vr = k;
            pv = vs_b;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL fs_pulses: got %0d expected 3", n); end
        checks++; if (p[0] !== 1) begin errors++; $display("FAIL fs_first: got cycle %0d expected 1", p[0]); end
        checks++; if (p[1] - p[0] !== 1760 || p[2] - p[1] !== 1760) begin errors++; $display("FAIL fs_period: got %0d %0d expected 1760", p[1] - p[0], p[2] - p[1]); end
        checks++; if (fc1 !== 1) begin errors++; $display("FAIL fcnt_first: got %0d expected 1", fc1); end
        checks++; if (fc3 !== 3) begin errors++; $display("FAIL fcnt_third: got %0d expected 3", fc3); end
        checks++; if (vf !== 1441) begin errors++; $display("FAIL vs_first_low: got cycle %0d expected 1441", vf); end
        checks++; if (vr - vf !== 160) begin errors++; $display("FAIL vs_width: got %0d expected 160", vr - vf); end
    endtask

    task automatic test_blanking();
        int bad, total, lines, run, bad_line;
        logic pd;
        bad = 0; total = 0; lines = 0; run = 0; bad_line = 0; pd = 1'b0;
        reset_b();
        for (int k = 1; k <= 1760; k++) begin
            @(posedge clk); #1;
            if (!de_b && {r_b, g_b, b_b} !== 12'h000) bad++;
            if (de_b && {r_b, g_b, b_b} !== 12'hFFF) bad++;
            if (de_b) begin
                total++;
                if (!pd) begin lines++; run = 0; end
                run++;
            end else if (pd && run != 64) bad_line++;
            pd = de_b;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL blank_rgb: got %0d bad samples expected 0", bad); end
        checks++; if (total !== 1024) begin errors++; $display("FAIL de_total: got %0d expected 1024", total); end
        checks++; if (lines !== 16) begin errors++; $display("FAIL active_lines: got %0d expected 16", lines); end
        checks++; if (bad_line !== 0) begin errors++; $display("FAIL line_len: got %0d bad lines expected 0", bad_line); end
    endtask

    task automatic test_mode();
        int mis, peak, set_k, hc, vc, ex, ey;
        mis = 0; peak = 0; set_k = 0;
        mode_b = 1'b0;
        reset_b();
        for (int k = 1; k <= 3520; k++) begin
            @(posedge clk); #1;
            hc = k % 80;
            vc = (k / 80) % 22;
            if (set_k == 0 && y_b == 5'd10) begin mode_b = 1'b1; set_k = k; end
            ex = k >= 1761 ? hc >> 1 : hc;
            ey = k >= 1761 ? vc >> 1 : vc;
            if (x_b !== 7'(ex) || y_b !== 5'(ey)) mis++;
            if (k >= 1761 && hc < 64 && int'(x_b) > peak) peak = int'(x_b);
        end
        checks++; if (set_k !== 800) begin errors++; $display("FAIL mode_line10: got cycle %0d expected 800", set_k); end
        checks++; if (mis !== 0) begin errors++; $display("FAIL mode_xy_seq: got %0d mismatches expected 0", mis); end
        checks++; if (peak !== 31) begin errors++; $display("FAIL mode_peak: got %0d expected 31", peak); end
        reset_b();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (x_b !== 7'd1) begin errors++; $display("FAIL mode_after_reset: got x=%0d expected 1", x_b); end
    endtask

    task automatic test_reset_midframe();
        int found, f1, hbad;
        logic p;
        found = 0; f1 = 0; hbad = 0; p = 1'b1;
        mode_b = 1'b0;
        reset_b();
        for (int k = 1; k <= 2000 && found == 0; k++) begin
            @(posedge clk); #1;
            if (y_b == 5'd19 && x_b == 7'd70) found = k;
        end
        checks++; if (found !== 1590 || hs_b !== 1'b0 || vs_b !== 1'b0) begin errors++; $display("FAIL midframe_point: got cycle %0d hs=%b vs=%b expected 1590 0 0", found, hs_b, vs_b); end
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk); #1;
        checks++; if ({x_b, y_b} !== 12'd0 || {hs_b, vs_b, de_b, fs_b} !== 4'b1100) begin errors++; $display("FAIL midreset_ctrl: got x=%0d y=%0d hs/vs/de/fs=%b expected 0 0 1100", x_b, y_b, {hs_b, vs_b, de_b, fs_b}); end
        checks++; if ({r_b, g_b, b_b} !== 12'h000 || fc_b !== 8'd0) begin errors++; $display("FAIL midreset_data: got rgb=%h fcnt=%0d expected 000 0", {r_b, g_b, b_b}, fc_b); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (p && !hs_b && f1 == 0) f1 = k;
            if (k < 69 && !hs_b) hbad++;
            p = hs_b;
        end
        checks++; if (f1 !== 69 || hbad !== 0) begin errors++; $display("FAIL midreset_hs: got first low %0d early lows %0d expected 69 0", f1, hbad); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
`ifdef VGA_PATTERN_EN
        test_pattern();
`endif
        test_frame();
        test_blanking();
        test_mode();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP, defaults 480, 10, 2, 33, in lines.
REQ-004 SHALL have parameters HS_POL and VS_POL, default 0 each; 0 means active-low sync.
REQ-005 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-006 SHALL have ports clk (input, 1 bit, pixel clock) and rst (input, 1 bit, synchronous active-low reset).
REQ-007 SHALL have port mode (input, 1 bit): 0 is native resolution, 1 is 2x pixel-doubled.
REQ-008 SHALL have port pix_in (input, 3*COLOR_W bits): external pixel {r,g,b} for the current x/y.
REQ-009 SHALL have ports x and y (outputs, clog2 of total width and clog2 of total height): current pixel coordinate.
REQ-010 SHALL have ports r, g, b (outputs, COLOR_W bits each), and hs, vs, de (outputs, 1 bit each).
REQ-011 SHALL have ports frame_start (output, 1 bit, one-cycle pulse) and frame_cnt (output, 8 bits).

Function
REQ-012 SHALL count h_cnt from 0 to H_TOT-1, where H_TOT = sum of the H_* parameters (800 by default), wrapping to 0.
REQ-013 SHALL increment v_cnt (0 to V_TOT-1, 525 by default) only when h_cnt wraps, and wrap v_cnt to 0 at the end of the last line.
REQ-014 SHALL define active video as h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-015 SHALL define sync as H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and the same form vertically.
REQ-016 SHALL, for x and y, be combinational from the counters: x = h_cnt and y = v_cnt when the active mode is 0; x = h_cnt>>1 and y = v_cnt>>1 when it is 1.
REQ-017 SHALL register hs, vs, de, r, g and b one cycle after the counters, so that the pixel requested at x/y in cycle n appears in cycle n+1.
REQ-018 SHALL drive r, g, b to 0 whenever the registered de is 0.
REQ-019 SHALL apply hs/vs polarity per HS_POL/VS_POL, so the inactive level is the inverse of the polarity.
REQ-020 SHALL sample the mode input only in the cycle where h_cnt = 0 and v_cnt = 0; a mid-frame change takes effect at the next frame.
REQ-021 SHALL pulse frame_start for one cycle, registered, in the cycle after h_cnt = 0 and v_cnt = 0.
REQ-022 SHALL increment frame_cnt in the same cycle as frame_start, wrapping from 255 to 0.

Reset
REQ-023 SHALL, when rst = 0 at a rising clk edge, set h_cnt = v_cnt = 0, active mode = 0, frame_cnt = 0, de = 0, frame_start = 0, r = g = b = 0, and hs/vs to their inactive level.
REQ-024 SHALL, on reset asserted mid-frame, restart from the top-left with no partial sync pulse extended.
REQ-025 SHALL sample mode on the first cycle after reset release.

Configuration
REQ-026 SHALL, when VGA_PATTERN_EN is defined, add input pat_sel (2 bits) that selects the rgb source:
- 0: pix_in.
- 1: 8 colour bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black.
- 2: checkerboard, white when x[4]^y[4] is 1, else black.
- 3: grey ramp, all channels = x[COLOR_W+5:6].
REQ-027 SHALL, when VGA_PATTERN_EN is undefined, omit pat_sel and always take rgb from pix_in.
REQ-028 SHALL have identical timing outputs with and without VGA_PATTERN_EN.

Structure
REQ-029 SHALL take from package vga_pkg: the default 640x480 timing localparams, a colour-bar lookup constant, and a function returning the counter width.
REQ-030 SHALL implement the h and v counters as two instances of sub-module vga_axis_counter.
REQ-031 vga_axis_counter SHALL have:
- parameters ACTIVE, FP, SYNC, BP;
- inputs clk, rst, inc;
- outputs cnt, active, sync, wrap.

Verification
REQ-032 SHALL test line timing with default parameters, rst = 0 for 4 cycles, then released: hs is 0 for exactly 96 cycles starting at cycle 657 after release, and the hs period is 800 cycles.
REQ-033 SHALL test frame timing with default parameters: vs is low for 2*800 cycles, the frame_start period is 420000 cycles, and frame_cnt reads 3 after the 3rd pulse.
REQ-034 SHALL test blanking with pix_in = 12'hFFF constant: r = g = b = 0 whenever de = 0, 640 de cycles per active line, and 480 active lines.
REQ-035 SHALL test mode switching by setting mode = 1 at line 100: x keeps the native sequence until the next frame_start, then x repeats each value twice (0,0,1,1,...) and peaks at 319.
REQ-036 SHALL test the pattern feature with VGA_PATTERN_EN defined and pat_sel = 1: {r,g,b} = 12'hFFF at x = 0, 12'hFF0 at x = 80, and 12'h000 at x = 600.
REQ-037 SHALL test reset mid-frame by asserting rst at line 200: outputs match the reset values the following cycle, and the first hs low after release occurs at cycle 657.
